// File: rtl/uart_rx_v.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM and a one-byte
// holding register with valid/ready handshake, framing-error pulse and sticky overrun.
module uart_rx_v #(
  parameter int BOARD_CK = 32000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV  = BOARD_CK / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  if (DIV < 4) begin : g_div_check
    $error("uart_rx_v: BOARD_CK/BAUD must be at least 4");
  end

  logic          sync1_reg;
  logic          rxs_reg;
  logic [2:0]    state_reg;
  logic [2:0]    state_next;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic [2:0]    idx_reg;
  logic [2:0]    idx_next;
  logic [7:0]    shift_reg;
  logic [7:0]    shift_next;
  logic [7:0]    data_reg;
  logic          valid_reg;
  logic          frame_err_reg;
  logic          overrun_reg;
  logic          busy_reg;
  logic          sample_bit;
  logic          byte_done;
  logic          stop_bad;
  logic          handshake;

  // Both flops idle high so a reset release never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= 1'b1;
      rxs_reg   <= 1'b1;
    end else begin
      sync1_reg <= rx;
      rxs_reg   <= sync1_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = (cnt_reg == DIV_LAST) ? '0 : cnt_reg + CNT_ONE;
    idx_next   = idx_reg;
    sample_bit = 1'b0;
    byte_done  = 1'b0;
    stop_bad   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
        if (!rxs_reg) begin
          state_next = S_START;
        end
      end
      S_START: begin
        if (cnt_reg == HALF_LAST) begin
          if (rxs_reg) begin
            state_next = S_IDLE;
          end else begin
            cnt_next   = '0;
            idx_next   = 3'd0;
            state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (cnt_reg == DIV_LAST) begin
          sample_bit = 1'b1;
          cnt_next   = '0;
          if (idx_reg == 3'd7) begin
            state_next = S_STOP;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (cnt_reg == DIV_LAST) begin
          cnt_next = '0;
          if (rxs_reg) begin
            byte_done  = 1'b1;
            state_next = S_IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // A held-low line stays here so it yields only one framing error.
        cnt_next = '0;
        if (rxs_reg) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = S_IDLE;
      end
    endcase
  end

  // Each shift-register bit loads only when its own index is being sampled.
  for (genvar gi = 0; gi < 8; gi++) begin : g_shift
    assign shift_next[gi] = (sample_bit && (idx_reg == 3'(gi))) ? rxs_reg : shift_reg[gi];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= 3'd0;
      shift_reg <= 8'h00;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      busy_reg  <= (state_next != S_IDLE);
    end
  end

  assign handshake = valid_reg & ready;

  // A completion in the same cycle as a handshake refills the register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg      <= 8'h00;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      frame_err_reg <= stop_bad;
      if (byte_done && (!valid_reg || ready)) begin
        data_reg  <= shift_reg;
        valid_reg <= 1'b1;
      end else if (handshake) begin
        valid_reg <= 1'b0;
      end
      if (handshake) begin
        overrun_reg <= 1'b0;
      end else if (byte_done && valid_reg) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign data      = data_reg;
  assign valid     = valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_uart_rx_v.sv
// Bench for uart_rx_v: directed and random frames on a DIV=16 instance with a
// scoreboard monitor, plus baud-tolerance frames on a default-parameter instance.
module tb_uart_rx_v;

  localparam int DIV  = 16;
  localparam int HALF = DIV / 2;

  logic       clk;
  logic       reset_n;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  logic       rx2;
  logic       ready2;
  logic [7:0] data2;
  logic       valid2;
  logic       frame_err2;
  logic       overrun2;
  logic       busy2;

  uart_rx_v #(.BOARD_CK(16), .BAUD(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .rx(rx), .data(data), .valid(valid),
    .ready(ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  uart_rx_v u_dut_def (
    .clk(clk), .reset_n(reset_n), .rx(rx2), .data(data2), .valid(valid2),
    .ready(ready2), .frame_err(frame_err2), .overrun(overrun2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] b;
  } ev_t;

  ev_t exp_q[$];
  int  hs_cyc[$];
  int  tests = 0;
  int  fails = 0;
  int  fe_count = 0;
  int  fe2_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back('{is_err: 1'b0, b: b});
  endtask

  task automatic expect_err();
    exp_q.push_back('{is_err: 1'b1, b: 8'h00});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (DIV) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  // Bit edges at round-down(i * num / den) cycles: fractional bit periods.
  task automatic send_frame2(input logic [7:0] b, input int num, input int den);
    logic [9:0] bits;
    int t_prev;
    int t_next;
    bits   = {1'b1, b, 1'b0};
    t_prev = 0;
    for (int i = 0; i < 10; i++) begin
      rx2    = bits[i];
      t_next = ((i + 1) * num) / den;
      repeat (t_next - t_prev) @(negedge clk);
      t_prev = t_next;
    end
    rx2 = 1'b1;
  endtask

  task automatic pulse_ready();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  // Scoreboard monitor: each handshake or frame_err pulse pops one expected event.
  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      #1;
      if (reset_n) begin
        if (frame_err) begin
          fe_count++;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_frame_err: got unexpected frame_err, expected no event");
          end else begin
            e = exp_q.pop_front();
            check("sb_event_is_err", 32'(e.is_err), 32'd1);
          end
        end
        if (valid && ready) begin
          hs_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_byte: got unexpected byte 0x%0h, expected no event", data);
          end else begin
            e = exp_q.pop_front();
            check("sb_event_is_byte", 32'(e.is_err), 32'd0);
            check("sb_data", 32'(data), 32'(e.b));
          end
        end
      end
    end
  end

  initial begin : monitor2
    forever begin
      @(negedge clk);
      #1;
      if (frame_err2) fe2_count++;
    end
  end

  initial begin : main
    int         c0;
    int         t_valid;
    logic       busy_at_valid;
    int         fe0;
    logic [7:0] b;
    logic       bad;

    reset_n = 1'b0;
    rx      = 1'b1;
    ready   = 1'b0;
    rx2     = 1'b1;
    ready2  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data", 32'(data), 32'h00);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    idle(5);

    // Single byte, ready low; latency = 2 sync + 1 IDLE edge + HALF + 9*DIV.
    expect_byte(8'hA5);
    c0 = cyc;
    t_valid = -1;
    busy_at_valid = 1'b1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          if (valid) begin
            t_valid = cyc;
            busy_at_valid = busy;
            break;
          end
        end
      end
    join
    check("single_latency", 32'(t_valid - c0), 32'(3 + HALF + 9 * DIV));
    check("single_data", 32'(data), 32'hA5);
    check("single_busy_low_at_valid", 32'(busy_at_valid), 32'd0);
    check("single_no_frame_err", 32'(fe_count), 32'd0);
    check("single_valid_held", 32'(valid), 32'd1);
    pulse_ready();
    check("single_valid_cleared", 32'(valid), 32'd0);
    check("single_data_kept", 32'(data), 32'hA5);

    // Back-to-back with ready tied high.
    ready = 1'b1;
    hs_cyc.delete();
    expect_byte(8'h00);
    expect_byte(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(20);
    check("b2b_count", 32'(hs_cyc.size()), 32'd2);
    if (hs_cyc.size() == 2) check("b2b_spacing", 32'(hs_cyc[1] - hs_cyc[0]), 32'(10 * DIV));
    ready = 1'b0;

    // Overrun: second byte dropped while the first is unconsumed.
    expect_byte(8'h11);
    send_frame(8'h11, 1'b1);
    idle(3);
    send_frame(8'h22, 1'b1);
    check("ovr_data", 32'(data), 32'h11);
    check("ovr_valid", 32'(valid), 32'd1);
    check("ovr_flag", 32'(overrun), 32'd1);
    pulse_ready();
    check("ovr_valid_cleared", 32'(valid), 32'd0);
    check("ovr_flag_cleared", 32'(overrun), 32'd0);

    // Short glitch is rejected.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    check("glitch_busy_up", 32'(busy), 32'd1);
    idle(30);
    check("glitch_busy_down", 32'(busy), 32'd0);
    check("glitch_no_valid", 32'(valid), 32'd0);

    // Bad stop bit.
    fe0 = fe_count;
    expect_err();
    send_frame(8'h96, 1'b0);
    idle(5);
    check("fstop_one_err", 32'(fe_count - fe0), 32'd1);
    check("fstop_no_valid", 32'(valid), 32'd0);
    check("fstop_busy_down", 32'(busy), 32'd0);

    // Line held low for 40 bit periods, then a clean frame.
    fe0 = fe_count;
    expect_err();
    rx = 1'b0;
    repeat (40 * DIV) @(negedge clk);
    check("break_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    idle(5);
    check("break_one_err", 32'(fe_count - fe0), 32'd1);
    check("break_busy_down", 32'(busy), 32'd0);
    expect_byte(8'h3C);
    send_frame(8'h3C, 1'b1);
    idle(2);
    check("break_then_data", 32'(data), 32'h3C);
    check("break_then_valid", 32'(valid), 32'd1);
    pulse_ready();

    // Asynchronous reset in the middle of data bit 4, with a byte pending.
    send_frame(8'h77, 1'b1);
    idle(2);
    check("prerst_valid", 32'(valid), 32'd1);
    fork
      send_frame(8'h5A, 1'b1);
      begin
        repeat (5 * DIV + 8) @(negedge clk);
        check("prerst_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_data", 32'(data), 32'h00);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
      end
    join
    idle(10);
    reset_n = 1'b1;
    idle(10);
    expect_byte(8'hC3);
    send_frame(8'hC3, 1'b1);
    idle(2);
    check("postrst_data", 32'(data), 32'hC3);
    pulse_ready();

    // Random frames, ready high, occasional bad stop bits.
    ready = 1'b1;
    for (int n = 0; n < 30; n++) begin
      b   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 99) < 15);
      if (bad) expect_err();
      else expect_byte(b);
      send_frame(b, !bad);
      idle(bad ? $urandom_range(2, 20) : $urandom_range(0, 20));
    end
    idle(30);
    ready = 1'b0;
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    // Default parameters: exact 115200 baud, then 3% fast.
    send_frame2(8'h55, 2500, 9);
    idle(50);
    check("def_exact_valid", 32'(valid2), 32'd1);
    check("def_exact_data", 32'(data2), 32'h55);
    check("def_exact_overrun", 32'(overrun2), 32'd0);
    check("def_exact_ferr", 32'(fe2_count), 32'd0);
    ready2 = 1'b1;
    @(negedge clk);
    ready2 = 1'b0;
    check("def_valid_cleared", 32'(valid2), 32'd0);
    send_frame2(8'h55, 250000, 927);
    idle(50);
    check("def_fast_valid", 32'(valid2), 32'd1);
    check("def_fast_data", 32'(data2), 32'h55);
    check("def_fast_overrun", 32'(overrun2), 32'd0);
    check("def_fast_ferr", 32'(fe2_count), 32'd0);
    check("def_busy_down", 32'(busy2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_v.md
# uart_rx_v

Asynchronous serial receiver (8N1, LSB first) that turns the board's `rx` pin into bytes for the SoC inside `dut`. It is the receiving end of the UART link whose transmit side drives `tx` toward the host. It has a 2-flop input synchronizer, a mid-bit sampling state machine and a one-byte holding register with a valid/ready handshake. It also reports framing-error and overrun status.

## Interface
- `BOARD_CK`, default 32000000: input clock frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s. The bit period is DIV = BOARD_CK/BAUD clock cycles, integer-truncated (277 at the defaults). DIV ≥ 4 is required; an elaboration-time check fails otherwise.
- `clk`  input  1  board clock; all state changes on its rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `rx`  input  1  serial line, idle high, asynchronous to `clk`.
- `data`  output  8  received byte; stable while `valid` = 1.
- `valid`  output  1  `data` holds an unconsumed byte.
- `ready`  input  1  consumer accepts the byte when `valid` & `ready` on a rising edge.
- `frame_err`  output  1  one-cycle pulse when a stop bit samples low.
- `overrun`  output  1  sticky; a byte completed while `valid` was still set.
- `busy`  output  1  state machine not in IDLE.

## Operation
- **Synchronizer:** `rx` passes through two flops to give `rxs`; both flops reset to 1. Only `rxs` is used downstream.
- **Counters:**
  - Bit-timer `cnt` is ceil(log2(DIV)) bits wide, counts up from 0, and wraps to 0 at DIV-1.
  - HALF = DIV/2, truncated.
  - Bit index `idx` is 3 bits.
- **States:**
  - IDLE: when `rxs` = 0, clear `cnt` and go to START.
  - START: when `cnt` = HALF-1, sample `rxs`. If it is 1 (glitch), go to IDLE with no output. If it is 0, clear `cnt` and `idx` and go to DATA.
  - DATA: when `cnt` = DIV-1, shift `rxs` into bit `idx` of the shift register (LSB first) and clear `cnt`. After `idx` = 7, go to STOP; otherwise increment `idx`.
  - STOP: when `cnt` = DIV-1, sample `rxs`.
    - If 1: complete the byte and go to IDLE.
    - If 0: pulse `frame_err`, discard the byte and go to BREAK.
  - BREAK: wait for `rxs` = 1, then go to IDLE. A held-low line produces exactly one `frame_err`.
- **Byte completion:**
  - If `valid` = 0, or `valid` & `ready` in that same cycle: load `data` and set `valid` = 1.
  - Otherwise keep the old `data`, drop the new byte and set `overrun` = 1.
- **Handshake:** `valid` & `ready` with no completion in the same cycle clears `valid`; `data` keeps its value. `ready` with `valid` = 0 has no effect.
- **Overrun clearing:** `overrun` clears on the next `valid` & `ready` handshake.
- **Reset:** `reset_n` low at any time, including mid-frame, forces IDLE and clears `cnt`, `idx`, the shift register, `data` (to 0x00), `valid`, `frame_err`, `overrun` and `busy`. A frame in progress at reset is lost. After release, reception resumes on the next `rxs` falling level.

## Timing
- Reset values: `data` = 0x00, `valid` = 0, `frame_err` = 0, `overrun` = 0, `busy` = 0.
- Pin-to-`rxs` latency is 2 cycles.
- Let cycle E be the first cycle in which `rxs` = 0 in IDLE.
  - Start is sampled at E+HALF.
  - Data bit k is sampled at E+HALF+(k+1)·DIV.
  - Stop is sampled at E+HALF+9·DIV.
  - `valid` or `frame_err` is visible from the following cycle.
- `busy` rises at E+1 and falls in the cycle after the stop sample, or in the cycle after `rxs` returns high when leaving BREAK.
- A new start bit immediately after the stop sample (zero idle time) is accepted; back-to-back frames are required to work.
- Tolerable baud mismatch is about ±4% (sampling stays within the bit across 10 bits).
- All outputs are registered; there are no combinational paths from `rx` or `ready`.

## Test plan
Directed scenarios use BOARD_CK = 16 and BAUD = 1, giving DIV = 16 and HALF = 8.
- **Single byte:** send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) with `ready` = 0. `valid` rises 1 cycle after the stop sample with `data` = 0xA5 and no `frame_err`. Pulse `ready` for 1 cycle: `valid` = 0 on the next cycle.
- **Back-to-back:** send 0x00 then 0xFF with zero idle time and `ready` tied to 1. Two `valid` pulses, exactly 10·DIV = 160 cycles apart, with `data` = 0x00 then 0xFF.
- **Overrun:** send 0x11 then 0x22 with `ready` = 0. `data` stays 0x11 and `overrun` = 1 after the second stop. A `ready` pulse clears both `valid` and `overrun`.
- **Glitch and framing:**
  - A 4-cycle low pulse on `rx` gives no `valid` and `busy` back to 0.
  - A frame with stop = 0 gives one `frame_err` pulse and `valid` stays 0.
  - `rx` held low for 40 bit periods gives exactly one `frame_err`. After `rx` returns high, 0x3C is received correctly.
- **Reset mid-frame:** assert `reset_n` = 0 asynchronously during data bit 4 of 0x5A. All outputs go to reset values immediately, without a clock edge. After release, sending 0xC3 gives `data` = 0xC3.
- **Default parameters:** with DIV = 277, send 0x55 at exactly 115200 baud (277.78 cycles/bit) and at +3%. Both give `data` = 0x55 and no errors.
